div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

  function automatic logic is_signed_op(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration; purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Shift in the next dividend bit and keep the difference only if it did not borrow.
  always_comb begin
    shifted_s = {rem, dvd_bit};
    trial_s   = shifted_s - {1'b0, divisor};
    if (trial_s[WIDTH]) begin
      q_bit    = 1'b0;
      rem_next = shifted_s[WIDTH-1:0];
    end else begin
      q_bit    = 1'b1;
      rem_next = trial_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit; WIDTH+1 cycle latency.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic [WIDTH-1:0] Result,
  output logic             Done,
  output logic             Busy,
  output logic             Stall
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state_r;
  div_op_t          op_r;
  logic [WIDTH-1:0] dvd_r, rem_r, dvs_r, result_r;
  logic             neg_q_r, neg_r_r, zero_r, done_r, busy_r;
  logic [CW-1:0]    cnt_r;

  div_op_t          op_s;
  logic             a_neg_s, b_neg_s, stall_s, q_bit_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, rem_next_s, quo_next_s, q_fin_s, r_fin_s;

  assign op_s       = div_op_t'(Op);
  assign a_neg_s    = is_signed_op(op_s) & A[WIDTH-1];
  assign b_neg_s    = is_signed_op(op_s) & B[WIDTH-1];
  assign a_mag_s    = a_neg_s ? ({WIDTH{1'b0}} - A) : A;
  assign b_mag_s    = b_neg_s ? ({WIDTH{1'b0}} - B) : B;
  assign quo_next_s = {dvd_r[WIDTH-2:0], q_bit_s};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .dvd_bit  (dvd_r[WIDTH-1]),
    .divisor  (dvs_r),
    .rem_next (rem_next_s),
    .q_bit    (q_bit_s)
  );

  // A zero divisor forces an all-ones quotient regardless of operand signs.
  assign q_fin_s = zero_r  ? {WIDTH{1'b1}} :
                   neg_q_r ? ({WIDTH{1'b0}} - quo_next_s) : quo_next_s;
  assign r_fin_s = neg_r_r ? ({WIDTH{1'b0}} - rem_next_s) : rem_next_s;

`ifdef DIV_EARLY_OUT_EN
  logic             b_zero_s, ovf_s, early_s;
  logic [WIDTH-1:0] early_res_s;
  assign b_zero_s    = (B == {WIDTH{1'b0}});
  assign ovf_s       = is_signed_op(op_s) & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == {WIDTH{1'b1}});
  assign early_s     = b_zero_s | ovf_s;
  assign early_res_s = is_rem_op(op_s) ? (b_zero_s ? A : {WIDTH{1'b0}})
                                       : (b_zero_s ? {WIDTH{1'b1}} : A);
`endif

  // Stall must see Start combinationally so the pipeline freezes in the accept cycle.
  always_comb begin
    if (rst) begin
      stall_s = 1'b0;
    end else if (state_r == BUSY) begin
      stall_s = 1'b1;
    end else if ((state_r == IDLE) && Start && !Flush) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Control FSM, operand latches, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      op_r     <= DIV;
      dvd_r    <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      zero_r   <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else if (Flush) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (Start) begin
            op_r    <= op_s;
            dvd_r   <= a_mag_s;
            rem_r   <= {WIDTH{1'b0}};
            dvs_r   <= b_mag_s;
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            zero_r  <= (B == {WIDTH{1'b0}});
            cnt_r   <= {CW{1'b0}};
`ifdef DIV_EARLY_OUT_EN
            if (early_s) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              busy_r   <= 1'b0;
              result_r <= early_res_s;
            end else begin
              state_r <= BUSY;
              busy_r  <= 1'b1;
            end
`else
            state_r <= BUSY;
            busy_r  <= 1'b1;
`endif
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        BUSY: begin
          dvd_r <= quo_next_s;
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r  <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= is_rem_op(op_r) ? r_fin_s : q_fin_s;
          end else begin
            state_r <= BUSY;
            busy_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Result = result_r;
  assign Done   = done_r;
  assign Busy   = busy_r;
  assign Stall  = stall_s;

endmodule
